dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the ARM pipeline's load/store port and an auxiliary requester (loader, debug or DMA) using a valid/ready handshake.
- The CPU has priority by default. A starvation counter forces an aux grant after MAX_WAIT consecutive lost cycles.
- Sits between the pipeline's memory-stage signals and dmem, inside the top-level processor wrapper.
- Drives a stall back to the pipeline and keeps a saturating count of CPU stall cycles.

Parameters:
WIDTH, 32, data and address width
MAX_WAIT, 4, consecutive cycles aux may be denied while valid; 0 means aux always wins a conflict
CNT_W, 16, width of the CPU stall-cycle counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
cpu_req  input  1  CPU memory access (load or store) this cycle
cpu_we  input  1  CPU store
cpu_adr  input  WIDTH  CPU address
cpu_wd  input  WIDTH  CPU store data
cpu_rd  output  WIDTH  CPU load data
cpu_stall  output  1  CPU access not serviced this cycle; pipeline must hold
aux_valid  input  1  aux request valid
aux_ready  output  1  aux request accepted this cycle
aux_we  input  1  aux write
aux_adr  input  WIDTH  aux address
aux_wd  input  WIDTH  aux write data
aux_rvalid  output  1  aux read data valid (one-cycle pulse)
aux_rd  output  WIDTH  registered aux read data
mem_we  output  1  to dmem write enable
mem_adr  output  WIDTH  to dmem address
mem_wd  output  WIDTH  to dmem write data
mem_rd  input  WIDTH  from dmem, combinational read
stall_cnt  output  CNT_W  saturating count of cycles with cpu_stall=1

Behaviour:
- dmem reads combinationally and writes on the rising clk edge when mem_we=1.

Grant rule (combinational):
- aux_grant = aux_valid & (~cpu_req | wait_cnt==MAX_WAIT) & ~reset.
- cpu_grant = cpu_req & ~aux_grant & ~reset.
- aux_ready = aux_grant.
- cpu_stall = cpu_req & ~cpu_grant & ~reset.

Mux:
- If aux_grant: mem_adr=aux_adr, mem_wd=aux_wd, mem_we=aux_we.
- Else: mem_adr=cpu_adr, mem_wd=cpu_wd, mem_we=cpu_we & cpu_grant.
- mem_we=0 whenever neither port is granted or reset=1.

Read paths:
- cpu_rd = mem_rd, combinational, zero latency. Valid only when cpu_grant=1; otherwise don't-care, though it still passes mem_rd through.
- Aux reads are registered. On an aux_grant cycle with aux_we=0, aux_rd <= mem_rd and aux_rvalid <= 1 on the next edge.
- aux_rvalid is 0 on every other cycle.
- aux_rd holds its value until the next aux read.

Starvation counter:
- wait_cnt is $clog2(MAX_WAIT+1) bits.
- If aux_valid & ~aux_ready: wait_cnt <= min(wait_cnt+1, MAX_WAIT).
- Otherwise wait_cnt <= 0. This covers both a completed handshake and aux_valid low.
- Guarantees aux is serviced within MAX_WAIT+1 cycles of asserting valid.
- After a forced aux grant the counter is 0, so the CPU wins the next conflict.

Aux protocol:
- Once aux_valid rises, aux_valid, aux_we, aux_adr and aux_wd are held stable until aux_ready.
- The arbiter does not check this; violating it is a bench error.
- A request is accepted in the same cycle as ready (zero-latency ready permitted).

stall_cnt:
- Increments by 1 on each edge where cpu_stall=1.
- Saturates at all-ones and does not wrap.

Reset (synchronous):
- wait_cnt=0, aux_rvalid=0, aux_rd=0, stall_cnt=0.
- While reset=1: aux_ready=0, cpu_stall=0, mem_we=0.
- Reset asserted mid-wait discards the pending aux wait count. The aux requester sees no ready and must re-present the request after reset.
- An aux read accepted on the cycle before reset produces no rvalid if reset is high on the following edge.

Simultaneous events:
- CPU store and aux write to the same address in the same cycle: only the granted port writes. The other is stalled or not readied and completes later, so last writer wins in grant order.

Test Plan:
- CPU only: store 0xDEADBEEF to 0x40, then load 0x40 → cpu_stall=0 throughout; cpu_rd=0xDEADBEEF in the load cycle; stall_cnt=0.
- Aux only: write 0x12345678 to 0x10, then read 0x10 → aux_ready=1 each request cycle; aux_rvalid pulses one cycle after the read with aux_rd=0x12345678.
- Starvation, MAX_WAIT=4: cpu_req held high, aux_valid raised at cycle 0 → aux_ready=0 for cycles 0–3 and =1 at cycle 4; cpu_stall=1 only at cycle 4; stall_cnt=1.
- Back-to-back conflicts with aux_valid held for 3 requests → grant pattern CPU×4, AUX, CPU×4, AUX, CPU×4, AUX; wait_cnt returns to 0 after each aux grant.
- Reset mid-operation: reset at cycle 2 of a starvation wait, released at cycle 4 → aux_ready=0 and mem_we=0 during reset; after release wait_cnt restarts from 0 and aux is granted 4 cycles later; stall_cnt=0.
- MAX_WAIT=0 variant: cpu_req and aux_valid both high → aux granted immediately; cpu_stall=1 for exactly that cycle.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU / auxiliary requester arbiter in front of the single-port data memory
//
// Purpose:
//   Shares one combinational-read / clocked-write data memory between the
//   pipeline load/store port and an auxiliary valid/ready requester. The CPU
//   wins conflicts by default; a starvation counter forces an aux grant once
//   aux has been refused MAX_WAIT consecutive cycles.
//
// Ports:
//   i_clk, i_reset                  clock, synchronous active-high reset
//   i_cpu_req/we/adr/wd             CPU access this cycle
//   o_cpu_rd, o_cpu_stall           CPU load data (pass-through), hold request
//   i_aux_valid/we/adr/wd           aux request, held stable until ready
//   o_aux_ready                     aux request accepted this cycle
//   o_aux_rvalid, o_aux_rd          registered aux read data, one-cycle pulse
//   o_mem_we/adr/wd, i_mem_rd       data memory port
//   o_stall_cnt                     saturating count of CPU stall cycles
module dmem_arbiter #(
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cpu_req,
    input  logic             i_cpu_we,
    input  logic [WIDTH-1:0] i_cpu_adr,
    input  logic [WIDTH-1:0] i_cpu_wd,
    output logic [WIDTH-1:0] o_cpu_rd,
    output logic             o_cpu_stall,
    input  logic             i_aux_valid,
    output logic             o_aux_ready,
    input  logic             i_aux_we,
    input  logic [WIDTH-1:0] i_aux_adr,
    input  logic [WIDTH-1:0] i_aux_wd,
    output logic             o_aux_rvalid,
    output logic [WIDTH-1:0] o_aux_rd,
    output logic             o_mem_we,
    output logic [WIDTH-1:0] o_mem_adr,
    output logic [WIDTH-1:0] o_mem_wd,
    input  logic [WIDTH-1:0] i_mem_rd,
    output logic [CNT_W-1:0] o_stall_cnt
);

    // MAX_WAIT=0 would give a zero-width counter; keep one bit, which then
    // stays at zero and compares equal to the limit on every cycle.
    localparam int WC_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(MAX_WAIT);

    logic [WC_W-1:0]  r_wait_cnt;
    logic             r_aux_rvalid;
    logic [WIDTH-1:0] r_aux_rd;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_wait_full;
    logic w_aux_grant;
    logic w_cpu_grant;
    logic w_cpu_stall;
    logic w_aux_read;

    // Grant: aux wins when the CPU is idle or aux has waited its limit.
    always_comb begin
        w_wait_full = (r_wait_cnt == WC_MAX);
        w_aux_grant = i_aux_valid & (~i_cpu_req | w_wait_full) & ~i_reset;
        w_cpu_grant = i_cpu_req & ~w_aux_grant & ~i_reset;
        w_cpu_stall = i_cpu_req & ~w_cpu_grant & ~i_reset;
        w_aux_read  = w_aux_grant & ~i_aux_we;
    end

    // Memory mux: the CPU side drives address/data whenever aux is not
    // granted, but only writes when actually granted.
    always_comb begin
        o_mem_adr = i_cpu_adr;
        o_mem_wd  = i_cpu_wd;
        o_mem_we  = i_cpu_we & w_cpu_grant;
        if (w_aux_grant) begin
            o_mem_adr = i_aux_adr;
            o_mem_wd  = i_aux_wd;
            o_mem_we  = i_aux_we;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wait_cnt   <= '0;
            r_aux_rvalid <= 1'b0;
            r_aux_rd     <= '0;
            r_stall_cnt  <= '0;
        end else begin
            // Count refused cycles; a grant or a dropped request restarts it,
            // so the CPU wins the conflict right after a forced aux grant.
            if (i_aux_valid & ~w_aux_grant) begin
                if (!w_wait_full) begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end
            end else begin
                r_wait_cnt <= '0;
            end

            r_aux_rvalid <= w_aux_read;
            if (w_aux_read) begin
                r_aux_rd <= i_mem_rd;
            end

            if (w_cpu_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign o_cpu_rd     = i_mem_rd;
    assign o_cpu_stall  = w_cpu_stall;
    assign o_aux_ready  = w_aux_grant;
    assign o_aux_rvalid = r_aux_rvalid;
    assign o_aux_rd     = r_aux_rd;
    assign o_stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a rule-level reference model
module tb_dmem_arbiter;

    localparam int W        = 32;
    localparam int MW       = 4;
    localparam int CW       = 4;
    localparam int CNT_MAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (MAX_WAIT=4, narrow counter so saturation is reachable)
    logic          reset, cpu_req, cpu_we, aux_valid, aux_we;
    logic [W-1:0]  cpu_adr, cpu_wd, aux_adr, aux_wd;
    logic [W-1:0]  cpu_rd, aux_rd, mem_adr, mem_wd, mem_rd;
    logic          cpu_stall, aux_ready, aux_rvalid, mem_we;
    logic [CW-1:0] stall_cnt;

    dmem_arbiter #(.WIDTH(W), .MAX_WAIT(MW), .CNT_W(CW)) u_dut (
        .i_clk(clk), .i_reset(reset),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_adr(cpu_adr), .i_cpu_wd(cpu_wd),
        .o_cpu_rd(cpu_rd), .o_cpu_stall(cpu_stall),
        .i_aux_valid(aux_valid), .o_aux_ready(aux_ready), .i_aux_we(aux_we),
        .i_aux_adr(aux_adr), .i_aux_wd(aux_wd),
        .o_aux_rvalid(aux_rvalid), .o_aux_rd(aux_rd),
        .o_mem_we(mem_we), .o_mem_adr(mem_adr), .o_mem_wd(mem_wd), .i_mem_rd(mem_rd),
        .o_stall_cnt(stall_cnt)
    );

    // Data memory attached to the main DUT
    logic [W-1:0] tb_mem [64];
    assign mem_rd = tb_mem[mem_adr[7:2]];
    always @(posedge clk) if (mem_we) tb_mem[mem_adr[7:2]] <= mem_wd;

    // Second DUT with MAX_WAIT=0, fixed memory read value
    logic          r0, c0_req, c0_we, a0_valid, a0_we;
    logic [W-1:0]  c0_rd, a0_rd, m0_adr, m0_wd;
    logic          c0_stall, a0_ready, a0_rvalid, m0_we;
    logic [CW-1:0] s0_cnt;
    logic [W-1:0]  m0_rd = 32'hA5A5_0F0F;

    dmem_arbiter #(.WIDTH(W), .MAX_WAIT(0), .CNT_W(CW)) u_dut0 (
        .i_clk(clk), .i_reset(r0),
        .i_cpu_req(c0_req), .i_cpu_we(c0_we), .i_cpu_adr(32'h0000_0020), .i_cpu_wd(32'h1111_1111),
        .o_cpu_rd(c0_rd), .o_cpu_stall(c0_stall),
        .i_aux_valid(a0_valid), .o_aux_ready(a0_ready), .i_aux_we(a0_we),
        .i_aux_adr(32'h0000_0030), .i_aux_wd(32'h2222_2222),
        .o_aux_rvalid(a0_rvalid), .o_aux_rd(a0_rd),
        .o_mem_we(m0_we), .o_mem_adr(m0_adr), .o_mem_wd(m0_wd), .i_mem_rd(m0_rd),
        .o_stall_cnt(s0_cnt)
    );

    // Scoreboard
    typedef struct {
        logic          ready, stall, we, rvalid, chk_rd;
        logic [W-1:0]  adr, wd, rd;
        logic [CW-1:0] scnt;
    } exp_t;

    exp_t         expq[$];
    logic [W-1:0] rdq[$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference model state: plain counts and a memory image
    logic [W-1:0] ref_mem [64];
    int  m_denied  = 0;
    int  m_stalls  = 0;
    bit  m_rv_next = 0;
    bit  m_aux_gnt = 0;

    task automatic drive(input bit rst, input bit creq, input bit cwe,
                         input logic [W-1:0] cadr, input logic [W-1:0] cwd,
                         input bit av, input bit awe,
                         input logic [W-1:0] aadr, input logic [W-1:0] awd);
        exp_t e;
        bit   cg;
        @(negedge clk);
        reset = rst; cpu_req = creq; cpu_we = cwe; cpu_adr = cadr; cpu_wd = cwd;
        aux_valid = av; aux_we = awe; aux_adr = aadr; aux_wd = awd;

        // Aux gets through if the CPU is idle or aux has been refused MW times.
        m_aux_gnt = av && !rst && (!creq || m_denied >= MW);
        cg        = creq && !m_aux_gnt && !rst;
        e.ready   = m_aux_gnt;
        e.stall   = creq && !cg && !rst;
        e.we      = m_aux_gnt ? awe : (cwe && cg);
        e.adr     = m_aux_gnt ? aadr : cadr;
        e.wd      = m_aux_gnt ? awd : cwd;
        e.chk_rd  = cg && !cwe;
        e.rd      = ref_mem[cadr[7:2]];
        e.rvalid  = m_rv_next;
        e.scnt    = CW'(m_stalls);
        expq.push_back(e);

        // Effects of the closing edge
        m_rv_next = m_aux_gnt && !awe;
        if (m_rv_next) rdq.push_back(ref_mem[aadr[7:2]]);
        if (e.we) ref_mem[e.adr[7:2]] = e.wd;
        if (rst) begin
            m_denied = 0;
            m_stalls = 0;
        end else begin
            if (e.stall && m_stalls < CNT_MAX) m_stalls++;
            m_denied = (av && !m_aux_gnt) ? m_denied + 1 : 0;
        end
    endtask

    // Monitor: pops one expectation per cycle, aux read data on each rvalid
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("aux_ready", aux_ready, e.ready);
                chk("cpu_stall", cpu_stall, e.stall);
                chk("mem_we", mem_we, e.we);
                chk("mem_adr", mem_adr, e.adr);
                chk("mem_wd", mem_wd, e.wd);
                chk("aux_rvalid", aux_rvalid, e.rvalid);
                chk("stall_cnt", stall_cnt, e.scnt);
                if (e.chk_rd) chk("cpu_rd", cpu_rd, e.rd);
                if (aux_rvalid === 1'b1) begin
                    if (rdq.size() == 0) fail_now("aux_rd_unexpected_rvalid");
                    else chk("aux_rd", aux_rd, rdq.pop_front());
                end
            end
        end
    end

    // Held aux request state (protocol: stable until ready)
    bit           a_v, a_we;
    logic [W-1:0] a_adr, a_wd;

    task automatic new_aux(input bit v);
        a_v   = v;
        a_we  = 1'($urandom_range(0, 1));
        a_adr = W'($urandom_range(0, 63)) << 2;
        a_wd  = $urandom;
    endtask

    task automatic cyc_conflict(input bit rst);
        drive(rst, 1'b1, 1'($urandom_range(0, 1)), W'($urandom_range(0, 63)) << 2, $urandom,
              a_v, a_we, a_adr, a_wd);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            tb_mem[i]  = '0;
            ref_mem[i] = '0;
        end
        reset = 1'b1; cpu_req = 0; cpu_we = 0; cpu_adr = '0; cpu_wd = '0;
        aux_valid = 0; aux_we = 0; aux_adr = '0; aux_wd = '0;
        r0 = 1'b1; c0_req = 0; c0_we = 0; a0_valid = 0; a0_we = 0;
        repeat (2) @(posedge clk);

        // Reset state
        repeat (2) drive(1, 0, 0, '0, '0, 0, 0, '0, '0);

        // CPU only: store then load
        drive(0, 1, 1, 32'h40, 32'hDEADBEEF, 0, 0, '0, '0);
        drive(0, 1, 0, 32'h40, '0, 0, 0, '0, '0);

        // Aux only: write then read, then idle to see rvalid
        drive(0, 0, 0, '0, '0, 1, 1, 32'h10, 32'h12345678);
        drive(0, 0, 0, '0, '0, 1, 0, 32'h10, '0);
        drive(0, 0, 0, '0, '0, 0, 0, '0, '0);

        // Starvation: aux held against a continuous CPU request
        a_v = 1; a_we = 0; a_adr = 32'h40; a_wd = '0;
        repeat (6) begin
            cyc_conflict(0);
            if (m_aux_gnt) a_v = 0;
        end

        // Back-to-back conflicts, aux re-presents three requests
        new_aux(1);
        for (int k = 0, n = 0; k < 20 && n < 3; k++) begin
            cyc_conflict(0);
            if (m_aux_gnt) begin
                n++;
                new_aux(1);
            end
        end
        a_v = 0;
        drive(0, 0, 0, '0, '0, 0, 0, '0, '0);

        // Reset in the middle of a starvation wait
        new_aux(1);
        repeat (2) cyc_conflict(0);
        repeat (2) cyc_conflict(1);
        for (int k = 0; k < 7; k++) begin
            cyc_conflict(0);
            if (m_aux_gnt) a_v = 0;
        end

        // Random traffic with occasional resets
        new_aux(0);
        for (int k = 0; k < 3000; k++) begin
            if (!a_v || m_aux_gnt) new_aux(1'($urandom_range(0, 1)));
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), W'($urandom_range(0, 63)) << 2, $urandom,
                  a_v, a_we, a_adr, a_wd);
        end

        // Saturate the stall counter with constant conflicts
        new_aux(1);
        repeat (120) begin
            cyc_conflict(0);
            if (m_aux_gnt) new_aux(1);
        end
        a_v = 0;
        repeat (3) drive(0, 0, 0, '0, '0, 0, 0, '0, '0);

        @(negedge clk);
        #5;
        if (expq.size() != 0) fail_now("scoreboard_expectations_left");
        if (rdq.size() != 0) fail_now("aux_read_data_never_returned");

        // MAX_WAIT=0: aux wins every conflict immediately
        @(negedge clk); r0 = 1'b0; c0_req = 1; c0_we = 1; a0_valid = 1; a0_we = 0;
        #3;
        chk("mw0_aux_ready", a0_ready, 1'b1);
        chk("mw0_cpu_stall", c0_stall, 1'b1);
        chk("mw0_mem_we", m0_we, 1'b0);
        chk("mw0_mem_adr", m0_adr, 32'h30);
        @(negedge clk); a0_valid = 0;
        #3;
        chk("mw0_cpu_stall_after", c0_stall, 1'b0);
        chk("mw0_mem_we_cpu", m0_we, 1'b1);
        chk("mw0_rvalid", a0_rvalid, 1'b1);
        chk("mw0_aux_rd", a0_rd, 32'hA5A5_0F0F);
        chk("mw0_stall_cnt", s0_cnt, 4'd1);
        @(negedge clk); c0_req = 0;
        #3;
        chk("mw0_rvalid_pulse", a0_rvalid, 1'b0);
        chk("mw0_stall_cnt_hold", s0_cnt, 4'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

endmodule
